// File: rtl/dist_ram_dp_clr_pkg.sv
// ----------------------------------------------------------------------------
// dist_ram_pkg
//  Shared definitions for the dual-port distributed RAM with clear sequencer.
//  - ST_CLEAR / ST_READY : clear-sequencer state encoding
//  - nbytes()            : number of 8-bit byte lanes in a data word
// ----------------------------------------------------------------------------
package dist_ram_pkg;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Word width is always a multiple of 8, so this is an exact division.
  function automatic int nbytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/dist_ram_dp_clr_if.sv
// ----------------------------------------------------------------------------
// dist_ram_dp_clr_if
//  Bus bundle for dist_ram_dp_clr.
//  Port A : a (addr), d (write data), we (write enable), be (byte lanes),
//           spo (read data of mem[a])
//  Port B : dpra (read addr), dpo (read data of mem[dpra])
//  Status : ready (clear sequence finished, user writes accepted)
//  Modports: master = user side, slave = RAM side.
// ----------------------------------------------------------------------------
interface dist_ram_dp_clr_if
  import dist_ram_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);

  localparam int NBYTES = nbytes(DATA_W);

  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  logic              we;
  logic [NBYTES-1:0] be;
  logic [DATA_W-1:0] spo;
  logic [ADDR_W-1:0] dpra;
  logic [DATA_W-1:0] dpo;
  logic              ready;

  modport master (
    output a, d, we, be, dpra,
    input  spo, dpo, ready
  );

  modport slave (
    input  a, d, we, be, dpra,
    output spo, dpo, ready
  );

endinterface

// File: rtl/dist_ram_clr_fsm.sv
// ----------------------------------------------------------------------------
// dist_ram_clr_fsm
//  Post-reset clear sequencer. After rst deasserts it walks clr_addr through
//  every word (one per clock) and asks the top level to write zero there. On
//  the edge that clears the last word it moves to READY and raises ready,
//  where it stays until the next rst.
//  Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   ready     : 1 once every word has been zeroed
//   clr_we    : 1 while the sequencer owns the write port
//   clr_addr  : word being cleared this cycle
// ----------------------------------------------------------------------------
module dist_ram_clr_fsm
  import dist_ram_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [0:0] state;

  // One word per clock; the edge that clears LAST_ADDR also raises ready,
  // so the whole clear takes exactly DEPTH cycles after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + ADDR_W'(1);
          if (clr_addr == LAST_ADDR) begin
            state <= ST_READY;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= ST_READY;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we = (state == ST_CLEAR);

endmodule

// File: rtl/dist_ram_dp_clr.sv
// ----------------------------------------------------------------------------
// dist_ram_dp_clr
//  Dual-port distributed RAM: port A synchronous write + read, port B
//  read-only. Byte-lane write enables. The array is zero-filled by
//  dist_ram_clr_fsm after every reset; user writes are ignored until ready.
//  Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dist_ram_dp_clr_if.slave (a, d, we, be, spo, dpra, dpo, ready)
//  Configuration:
//   DIST_RAM_OUT_REG_EN undefined : spo/dpo combinational (0-cycle latency)
//   DIST_RAM_OUT_REG_EN defined   : spo/dpo registered, read-first,
//                                   1-cycle latency
//  spo/dpo read as 0 while ready is low.
// ----------------------------------------------------------------------------
module dist_ram_dp_clr
  import dist_ram_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dist_ram_dp_clr_if.slave      bus
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBYTES = nbytes(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              ready;

  dist_ram_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign bus.ready = ready;

  // The array has no reset of its own; the clear sequencer owns the write
  // port until it finishes, so user we/be are simply ignored meanwhile.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (ready && bus.we) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (bus.be[i]) begin
          mem[bus.a][8*i +: 8] <= bus.d[8*i +: 8];
        end
      end
    end
  end

`ifdef DIST_RAM_OUT_REG_EN
  logic [DATA_W-1:0] spo_q;
  logic [DATA_W-1:0] dpo_q;

  // Registered read samples the array before this edge's write lands,
  // which gives read-first behaviour on a same-address write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spo_q <= '0;
      dpo_q <= '0;
    end else if (!ready) begin
      spo_q <= '0;
      dpo_q <= '0;
    end else begin
      spo_q <= mem[bus.a];
      dpo_q <= mem[bus.dpra];
    end
  end

  assign bus.spo = spo_q;
  assign bus.dpo = dpo_q;
`else
  assign bus.spo = ready ? mem[bus.a]    : '0;
  assign bus.dpo = ready ? mem[bus.dpra] : '0;
`endif

endmodule
